// File: rtl/invader_pkg.sv
// Shared types and geometry helpers for the invader row controller.
package invader_pkg;

  import vga_pkg::*;

  typedef enum logic [2:0] {
    MOVE_R,
    MOVE_L,
    DROP_TO_L,
    DROP_TO_R,
    HALT
  } move_state_e;

  localparam int DEF_NUM_INVADERS   = 10;
  localparam int DEF_INVADER_WIDTH  = 64;
  localparam int DEF_INVADER_HEIGHT = 48;
  localparam int DEF_X_INIT         = 32;
  localparam int DEF_Y_INIT         = 100;
  localparam int DEF_OFFSET         = 100;
  localparam int DEF_STEP_X         = 8;
  localparam int DEF_STEP_Y         = 16;
  localparam int DEF_Y_LIMIT        = 700;
  localparam int DEF_MIN_PERIOD     = 2;
  localparam int DEF_PERIOD_PER_INV = 3;

  // Column spacing: spread the leftover width evenly over the gaps between sprites.
  function automatic int pitch(input int num, input int width, input int offset);
    return width + ((HOR_PIXELS - offset) - num * width) / (num - 1);
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// Display timing constants shared across the video pipeline (1024x768 @ 60 Hz, 65 MHz pixel clock).
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

endpackage

// File: rtl/invader_extent.sv
// Combinational first/last alive column and alive count of the invader mask.
module invader_extent #(
  parameter  int N     = 10,
  localparam int IDX_W = $clog2(N),
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     mask_i,
  output logic [IDX_W-1:0] first_o,
  output logic [IDX_W-1:0] last_o,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
    first_o = '0;
    last_o  = '0;
    count_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) first_o = IDX_W'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (mask_i[i]) begin
        last_o  = IDX_W'(i);
        count_o = count_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/invader_move_ctrl.sv
// Invader row motion: frame-paced stepping right/left with drops, halting at the invasion line.
module invader_move_ctrl
  import invader_pkg::*;
  import vga_pkg::*;
#(
  parameter int NUM_INVADERS   = DEF_NUM_INVADERS,
  parameter int INVADER_WIDTH  = DEF_INVADER_WIDTH,
  parameter int INVADER_HEIGHT = DEF_INVADER_HEIGHT,
  parameter int X_INIT         = DEF_X_INIT,
  parameter int Y_INIT         = DEF_Y_INIT,
  parameter int OFFSET         = DEF_OFFSET,
  parameter int STEP_X         = DEF_STEP_X,
  parameter int STEP_Y         = DEF_STEP_Y,
  parameter int Y_LIMIT        = DEF_Y_LIMIT,
  parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
  parameter int PERIOD_PER_INV = DEF_PERIOD_PER_INV
) (
  input  logic                    clk65MHz,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    game_run,
  input  logic [NUM_INVADERS-1:0] invader_enable,
  output logic [9:0]              xpos,
  output logic [9:0]              ypos,
  output logic                    step_pulse,
  output logic                    bottom_reached,
  output logic                    all_cleared
);

  localparam int IDX_W = $clog2(NUM_INVADERS);
  localparam int CNT_W = $clog2(NUM_INVADERS + 1);
  localparam int PER_W = 16;
  localparam int PITCH = pitch(NUM_INVADERS, INVADER_WIDTH, OFFSET);

  logic [IDX_W-1:0] first_c, last_c, first_q, last_q;
  logic [CNT_W-1:0] count_c, count_q;
  logic             valid_q;

  move_state_e      state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d, period;
  logic [9:0]       xpos_q, xpos_d, ypos_q, ypos_d;
  logic             step_q, step_d, bottom_q, bottom_d;
  logic             active, fire, right_ok, bottom_hit;

  invader_extent #(.N(NUM_INVADERS)) u_extent (
    .mask_i  (invader_enable),
    .first_o (first_c),
    .last_o  (last_c),
    .count_o (count_c)
  );

  // The motion rules only need the right edge; the left extent is kept alongside for completeness.
  logic unused_first;
  assign unused_first = ^first_q;

  assign period     = PER_W'(MIN_PERIOD) + PER_W'(count_q) * PER_W'(PERIOD_PER_INV);
  assign active     = game_run && valid_q && (count_q != '0);
  assign fire       = active && frame_tick && (cnt_q >= period - PER_W'(1));
  assign right_ok   = (X_INIT + int'(xpos_q) + STEP_X + int'(last_q) * PITCH + INVADER_WIDTH)
                      <= HOR_PIXELS;
  assign bottom_hit = (Y_INIT + int'(ypos_q) + STEP_Y + INVADER_HEIGHT) >= Y_LIMIT;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    step_d   = 1'b0;
    bottom_d = bottom_q;

    // >= rather than == so a period that shrank under the count fires on the next tick.
    if (active && frame_tick) begin
      if (cnt_q >= period - PER_W'(1)) cnt_d = '0;
      else                             cnt_d = cnt_q + PER_W'(1);
    end

    if (fire && state_q != HALT) begin
      step_d = 1'b1;
      case (state_q)
        MOVE_R: begin
          if (right_ok) xpos_d  = xpos_q + 10'(STEP_X);
          else          state_d = DROP_TO_L;
        end
        MOVE_L: begin
          if (int'(xpos_q) >= STEP_X) xpos_d  = xpos_q - 10'(STEP_X);
          else                        state_d = DROP_TO_R;
        end
        DROP_TO_L, DROP_TO_R: begin
          ypos_d = ypos_q + 10'(STEP_Y);
          if (bottom_hit) begin
            state_d  = HALT;
            bottom_d = 1'b1;
          end else begin
            state_d = (state_q == DROP_TO_L) ? MOVE_L : MOVE_R;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk65MHz) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (rst) begin
      first_q  <= '0;
      last_q   <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      state_q  <= MOVE_R;
      cnt_q    <= '0;
      xpos_q   <= '0;
      ypos_q   <= '0;
      step_q   <= 1'b0;
      bottom_q <= 1'b0;
    end else begin
      first_q  <= first_c;
      last_q   <= last_c;
      count_q  <= count_c;
      valid_q  <= 1'b1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      step_q   <= step_d;
      bottom_q <= bottom_d;
    end
  end

  assign xpos           = xpos_q;
  assign ypos           = ypos_q;
  assign step_pulse     = step_q;
  assign bottom_reached = bottom_q;
  assign all_cleared    = valid_q && (count_q == '0);

endmodule

// File: doc/invader_move_ctrl.md
INVADER_MOVE_CTRL -- requirements
Module: invader_move_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- NUM_INVADERS, 10, columns in the row
- INVADER_WIDTH, 64, sprite width in px
- INVADER_HEIGHT, 48, sprite height in px
- X_INIT, 32, row origin x in px
- Y_INIT, 100, row origin y in px
- OFFSET, 100, horizontal margin used for spacing
- STEP_X, 8, horizontal px per step
- STEP_Y, 16, vertical px per drop
- Y_LIMIT, 700, invasion line y in px
- MIN_PERIOD, 2, frames per step with 0 alive
- PERIOD_PER_INV, 3, added frames per alive invader
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
- clk65MHz, in, 1, pixel clock
- rst, in, 1, synchronous active-high reset
- frame_tick, in, 1, one-cycle pulse per frame
- game_run, in, 1, motion enable
- invader_enable, in, NUM_INVADERS, alive mask
- xpos, out, 10, row x offset from X_INIT
- ypos, out, 10, row y offset from Y_INIT
- step_pulse, out, 1, one cycle per executed move
- bottom_reached, out, 1, sticky invasion flag
- all_cleared, out, 1, high while the mask is all zero
REQ-003 Reset SHALL be rst, synchronous, active-high; the clock SHALL be clk65MHz.

Function
REQ-004 PITCH SHALL be INVADER_WIDTH + ((HOR_PIXELS-OFFSET) - NUM_INVADERS*INVADER_WIDTH)/(NUM_INVADERS-1); defaults give 95.
REQ-005 first/last alive column index and alive count SHALL be registered once per cycle from invader_enable (1-cycle latency).
REQ-006 Step period SHALL be MIN_PERIOD + alive_count*PERIOD_PER_INV frames (default 32 with 10 alive); a frame counter SHALL increment on frame_tick and fire a step when it reaches period-1, then clear to 0.
REQ-007 If the period shrinks below the counter value, the next frame_tick SHALL fire a step immediately.
REQ-008 FSM states SHALL be MOVE_R, MOVE_L, DROP_TO_L, DROP_TO_R, HALT; reset state MOVE_R.
REQ-009 MOVE_R step: if X_INIT+xpos+STEP_X+last*PITCH+INVADER_WIDTH <= HOR_PIXELS then xpos += STEP_X, else go to DROP_TO_L with no x change.
REQ-010 MOVE_L step: if xpos >= STEP_X then xpos -= STEP_X, else go to DROP_TO_R with no x change.
REQ-011 DROP_TO_L/DROP_TO_R step: ypos += STEP_Y, then go to MOVE_L/MOVE_R respectively.
REQ-012 When Y_INIT+ypos+INVADER_HEIGHT >= Y_LIMIT, the FSM SHALL enter HALT and set bottom_reached, sticky until reset.
REQ-013 all_cleared SHALL be high while invader_enable == 0; the counter and FSM SHALL hold and no step SHALL fire during that time.
REQ-014 game_run low SHALL freeze the counter, FSM, xpos and ypos; frame_tick is ignored.
REQ-015 xpos, ypos and the state SHALL update in the cycle after the qualifying frame_tick; step_pulse SHALL be high in that same cycle, including for drop steps.
REQ-016 HALT SHALL be left only by reset.

Reset
REQ-017 On rst, outputs SHALL be xpos=0, ypos=0, step_pulse=0, bottom_reached=0, and all_cleared=0 until the registered mask is evaluated; state SHALL be MOVE_R and the counter 0.
REQ-018 Reset asserted mid-step SHALL take priority over any update in the same cycle.

Structure
REQ-019 The state enum, PITCH formula and STEP/period constants SHALL live in a shared invader_pkg; HOR_PIXELS SHALL come from vga_pkg.
REQ-020 One sub-module, invader_extent, SHALL compute first, last and popcount of the mask combinationally.

Verification
REQ-021 All alive, game_run=1, 32 frame_ticks -> xpos=8 with a single step_pulse on tick 32.
REQ-022 All alive -> xpos saturates at 72; next step ypos=16 and xpos stays 72; following steps decrement xpos by 8.
REQ-023 Mask 0x1FF (column 9 dead), period 29 -> right limit xpos=168.
REQ-024 Repeated drops -> at ypos=560 (100+560+48 >= 700) state is HALT, bottom_reached=1, and no further motion.
REQ-025 Mask 0 -> all_cleared=1 with no step_pulse; game_run=0 for 100 ticks -> positions are unchanged.
REQ-026 rst at xpos=40 -> next cycle xpos=0, ypos=0, state MOVE_R.
